// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the machine-control sequencer.
//   state_t       : controller state, fixed 2-bit encoding
//   ERR_INACTIVE  : idle level of a motor error input (active high)
//   SENS_INACTIVE : idle level of a fail sensor input (active low)
package mc_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'b00,
    STAGGER = 2'b01,
    RUN     = 2'b10,
    FAULT   = 2'b11
  } state_t;

  localparam logic ERR_INACTIVE  = 1'b0;
  localparam logic SENS_INACTIVE = 1'b1;

endpackage

// File: rtl/machine_control_seq_if.sv
// machine_control_seq_if: operator/plant signal bundle of the machine controller.
//   mot_err     : per-motor error, active high, asynchronous
//   fail_sens_n : fail sensors, active low, asynchronous
//   start/stop/fault_ack : operator commands, level sampled
//   mot_ena     : motor enables
//   led_green/led_red : status LEDs
//   fault_src   : latched fault sources {sensors, motors}
// master drives the plant/operator side, slave is the controller.
interface machine_control_seq_if #(
  parameter int N_MOT  = 5,
  parameter int N_SENS = 3
);
  logic [N_MOT-1:0]        mot_err;
  logic [N_SENS-1:0]       fail_sens_n;
  logic                    start;
  logic                    stop;
  logic                    fault_ack;
  logic [N_MOT-1:0]        mot_ena;
  logic                    led_green;
  logic                    led_red;
  logic [N_MOT+N_SENS-1:0] fault_src;

  modport master (
    output mot_err, fail_sens_n, start, stop, fault_ack,
    input  mot_ena, led_green, led_red, fault_src
  );

  modport slave (
    input  mot_err, fail_sens_n, start, stop, fault_ack,
    output mot_ena, led_green, led_red, fault_src
  );
endinterface

// File: rtl/mc_debounce.sv
// mc_debounce: 2-FF synchroniser followed by a per-bit stability counter.
// A bit's output takes the new level after DEBOUNCE_CYC consecutive
// synchronised samples that differ from it; any matching sample restarts
// the count.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous inputs
//   dout       : debounced outputs (reset to RST_VAL)
module mc_debounce #(
  parameter int                WIDTH        = 1,
  parameter int                DEBOUNCE_CYC = 4,
  parameter logic [WIDTH-1:0]  RST_VAL      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int             CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // NOTE: non-blocking assignments make sync1 -> sync2 a real two-stage
  // pipeline; blocking ones would collapse it into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          deb;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        deb <= RST_VAL[i];
      end else if (sync2[i] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign dout[i] = deb;
  end

endmodule

// File: rtl/machine_control_seq.sv
// machine_control_seq: top-level sequencer for N_MOT motors and N_SENS
// active-low fail sensors. Faults are debounced, motors are started one
// every START_GAP cycles, and faults latch with a source snapshot until
// acknowledged while the sources are clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : machine_control_seq_if.slave (inputs, enables, LEDs, sources)
// Build option: define MC_LED_BLINK_EN to blink the green LED during
// STAGGER and the red LED while an active fault is present.
module machine_control_seq
  import mc_pkg::*;
#(
  parameter int N_MOT        = 5,
  parameter int N_SENS       = 3,
  parameter int DEBOUNCE_CYC = 4,
  parameter int START_GAP    = 8,
  parameter int BLINK_DIV    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  machine_control_seq_if.slave  bus
);

  localparam int               NW      = N_MOT + N_SENS;
  localparam int               GW      = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam logic [GW-1:0]    GAP_MAX = GW'(START_GAP - 1);
  localparam logic [N_MOT-1:0] ALL_ON  = '1;

  logic [N_MOT-1:0]  deb_err;
  logic [N_SENS-1:0] deb_sens;
  logic [NW-1:0]     flt_vec;
  logic              fault;

  mc_debounce #(
    .WIDTH(N_MOT), .DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL({N_MOT{ERR_INACTIVE}})
  ) u_deb_err (
    .clk(clk), .rst_n(rst_n), .din(bus.mot_err), .dout(deb_err)
  );

  mc_debounce #(
    .WIDTH(N_SENS), .DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL({N_SENS{SENS_INACTIVE}})
  ) u_deb_sens (
    .clk(clk), .rst_n(rst_n), .din(bus.fail_sens_n), .dout(deb_sens)
  );

  assign flt_vec = {~deb_sens, deb_err};
  assign fault   = |flt_vec;

  state_t           state_q, state_d;
  logic [N_MOT-1:0] ena_q, ena_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [NW-1:0]    src_q, src_d;
  logic             green_q, green_d;
  logic             red_q, red_d;
  logic             blink;

`ifdef MC_LED_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  // Free-running: only reset clears it, state changes do not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b1;
`endif

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ena_d   = ena_q;
    gap_d   = gap_q;
    src_d   = src_q;

    unique case (state_q)
      INIT: begin
        ena_d = '0;
        gap_d = '0;
        if (fault) begin
          state_d = FAULT;
          src_d   = flt_vec;
        end else if (!bus.stop && bus.start) begin
          ena_d   = N_MOT'(1);
          state_d = (ena_d == ALL_ON) ? RUN : STAGGER;
        end
      end

      STAGGER, RUN: begin
        if (fault) begin
          state_d = FAULT;
          ena_d   = '0;
          src_d   = flt_vec;
        end else if (bus.stop) begin
          state_d = INIT;
          ena_d   = '0;
        end else if (state_q == STAGGER) begin
          if (gap_q == GAP_MAX) begin
            // Thermometer fill: one more motor from bit 0 upward.
            ena_d = (ena_q << 1) | N_MOT'(1);
            gap_d = '0;
            if (ena_d == ALL_ON) state_d = RUN;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end

      FAULT: begin
        ena_d = '0;
        src_d = src_q | flt_vec;
        if (bus.fault_ack && !fault) begin
          state_d = INIT;
          src_d   = '0;
        end
      end

      default: state_d = INIT;
    endcase

    // LEDs follow the state being entered so they change with MOT_ENA.
    green_d = (state_d == RUN) || ((state_d == STAGGER) && blink);
    red_d   = (state_d == FAULT) && (!fault || blink);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ena_q   <= '0;
      gap_q   <= '0;
      src_q   <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ena_q   <= ena_d;
      gap_q   <= gap_d;
      src_q   <= src_d;
      green_q <= green_d;
      red_q   <= red_d;
    end
  end

  assign bus.mot_ena   = ena_q;
  assign bus.led_green = green_q;
  assign bus.led_red   = red_q;
  assign bus.fault_src = src_q;

endmodule

// File: tb/tb_machine_control_seq.sv
// Testbench for machine_control_seq at default parameters (steady LEDs).
module tb_machine_control_seq;

  localparam int N_MOT  = 5;
  localparam int N_SENS = 3;
  localparam int DEB    = 4;
  localparam int GAP    = 8;
  localparam int NW     = N_MOT + N_SENS;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FLT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  machine_control_seq_if #(.N_MOT(N_MOT), .N_SENS(N_SENS)) bus ();

  machine_control_seq #(
    .N_MOT(N_MOT), .N_SENS(N_SENS), .DEBOUNCE_CYC(DEB),
    .START_GAP(GAP), .BLINK_DIV(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: motors counted from elapsed time since START, the
  // debouncer expressed as a sliding window over raw fault samples.
  logic [NW-1:0] hist[$];
  logic [NW-1:0] m_deb;
  int            m_mode;
  int            m_elapsed;
  logic [NW-1:0] m_src;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
    m_deb     = '0;
    m_mode    = M_IDLE;
    m_elapsed = 0;
    m_src     = '0;
  endtask

  task automatic model_step(input logic s, input logic st, input logic a,
                            input logic [NW-1:0] raw);
    logic          f;
    logic          all_diff;
    logic [NW-1:0] flip;
    f = |m_deb;
    case (m_mode)
      M_IDLE: begin
        if (f) begin
          m_mode = M_FLT;
          m_src  = m_deb;
        end else if (!st && s) begin
          m_mode    = M_RUN;
          m_elapsed = 0;
        end
      end
      M_RUN: begin
        if (f) begin
          m_mode = M_FLT;
          m_src  = m_deb;
        end else if (st) begin
          m_mode = M_IDLE;
        end else if (m_elapsed < N_MOT * GAP) begin
          m_elapsed++;
        end
      end
      default: begin
        m_src = m_src | m_deb;
        if (a && !f) begin
          m_mode = M_IDLE;
          m_src  = '0;
        end
      end
    endcase
    // Window holds raw samples of edges k-DEB-1 .. k; the synchronised
    // samples seen by the counter are the oldest DEB of them.
    hist.push_back(raw);
    void'(hist.pop_front());
    flip = '0;
    for (int b = 0; b < NW; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hist[j][b] == m_deb[b]) all_diff = 1'b0;
      flip[b] = all_diff;
    end
    m_deb = m_deb ^ flip;
  endtask

  function automatic logic [14:0] model_out();
    logic [N_MOT-1:0] ena;
    int n;
    ena = '0;
    if (m_mode == M_RUN) begin
      n = m_elapsed / GAP + 1;
      if (n > N_MOT) n = N_MOT;
      for (int i = 0; i < n; i++) ena[i] = 1'b1;
    end
    return {ena, (m_mode == M_RUN), (m_mode == M_FLT), m_src};
  endfunction

  function automatic logic [14:0] dut_out();
    return {bus.mot_ena, bus.led_green, bus.led_red, bus.fault_src};
  endfunction

  task automatic drive(input logic s, input logic st, input logic a,
                       input logic [N_MOT-1:0] e, input logic [N_SENS-1:0] sn);
    bus.start       = s;
    bus.stop        = st;
    bus.fault_ack   = a;
    bus.mot_err     = e;
    bus.fail_sens_n = sn;
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step(bus.start, bus.stop, bus.fault_ack, {~bus.fail_sens_n, bus.mot_err});
    @(negedge clk);
    check({tag, "_model"}, 32'(dut_out()), 32'(model_out()));
  endtask

  typedef struct {
    string            name;
    logic             start, stop, ack;
    logic [N_MOT-1:0] err;
    logic [N_SENS-1:0] sens_n;
    int               hold;
    logic [N_MOT-1:0] ena;
    logic             g, r;
    logic [NW-1:0]    src;
  } row_t;

  row_t rows[$];

  initial begin
    logic [N_MOT-1:0]  r_err;
    logic [N_SENS-1:0] r_sens;

    drive(0, 0, 0, '0, '1);
    model_reset();

    // name, start, stop, ack, err, sens_n, hold, ena, green, red, src
    rows.push_back('{"idle",          0,0,0, 5'h00, 3'b111,  2, 5'h00, 0,0, 8'h00});
    rows.push_back('{"start",         1,0,0, 5'h00, 3'b111,  1, 5'h01, 1,0, 8'h00});
    rows.push_back('{"stag_m0",       0,0,0, 5'h00, 3'b111,  7, 5'h01, 1,0, 8'h00});
    rows.push_back('{"stag_m1",       0,0,0, 5'h00, 3'b111,  1, 5'h03, 1,0, 8'h00});
    rows.push_back('{"stag_m2",       0,0,0, 5'h00, 3'b111,  8, 5'h07, 1,0, 8'h00});
    rows.push_back('{"stag_m3",       0,0,0, 5'h00, 3'b111,  8, 5'h0F, 1,0, 8'h00});
    rows.push_back('{"run_all",       0,0,0, 5'h00, 3'b111,  8, 5'h1F, 1,0, 8'h00});
    rows.push_back('{"run_start_ign", 1,0,0, 5'h00, 3'b111,  3, 5'h1F, 1,0, 8'h00});
    rows.push_back('{"glitch3",       0,0,0, 5'h04, 3'b111,  3, 5'h1F, 1,0, 8'h00});
    rows.push_back('{"glitch_settle", 0,0,0, 5'h00, 3'b111,  8, 5'h1F, 1,0, 8'h00});
    rows.push_back('{"err_pre",       0,0,0, 5'h01, 3'b111,  6, 5'h1F, 1,0, 8'h00});
    rows.push_back('{"err_hit",       0,0,0, 5'h01, 3'b111,  1, 5'h00, 0,1, 8'h01});
    rows.push_back('{"err_hold",      0,0,0, 5'h01, 3'b111,  3, 5'h00, 0,1, 8'h01});
    rows.push_back('{"err_gone",      0,0,0, 5'h00, 3'b111, 10, 5'h00, 0,1, 8'h01});
    rows.push_back('{"ack_err",       0,0,1, 5'h00, 3'b111,  1, 5'h00, 0,0, 8'h00});
    rows.push_back('{"start2",        1,0,0, 5'h00, 3'b111,  1, 5'h01, 1,0, 8'h00});
    rows.push_back('{"stag2",         0,0,0, 5'h00, 3'b111, 32, 5'h1F, 1,0, 8'h00});
    rows.push_back('{"sens_fault",    0,0,0, 5'h00, 3'b110,  7, 5'h00, 0,1, 8'h20});
    rows.push_back('{"ack_ignored",   0,0,1, 5'h00, 3'b110,  3, 5'h00, 0,1, 8'h20});
    rows.push_back('{"sens_gone",     0,0,0, 5'h00, 3'b111,  7, 5'h00, 0,1, 8'h20});
    rows.push_back('{"ack_sens",      0,0,1, 5'h00, 3'b111,  1, 5'h00, 0,0, 8'h00});
    rows.push_back('{"start3",        1,0,0, 5'h00, 3'b111,  1, 5'h01, 1,0, 8'h00});
    rows.push_back('{"stag3",         0,0,0, 5'h00, 3'b111,  8, 5'h03, 1,0, 8'h00});
    rows.push_back('{"stop",          0,1,0, 5'h00, 3'b111,  1, 5'h00, 0,0, 8'h00});
    rows.push_back('{"start4",        1,0,0, 5'h00, 3'b111,  1, 5'h01, 1,0, 8'h00});
    rows.push_back('{"err_arm",       0,0,0, 5'h02, 3'b111,  6, 5'h01, 1,0, 8'h00});
    rows.push_back('{"stop_vs_fault", 0,1,0, 5'h02, 3'b111,  1, 5'h00, 0,1, 8'h02});
    rows.push_back('{"clear",         0,0,0, 5'h00, 3'b111,  8, 5'h00, 0,1, 8'h02});
    rows.push_back('{"ack_final",     0,0,1, 5'h00, 3'b111,  1, 5'h00, 0,0, 8'h00});

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ena", 32'(bus.mot_ena), 32'h0);
    check("reset_leds", 32'({bus.led_green, bus.led_red}), 32'h0);
    check("reset_src", 32'(bus.fault_src), 32'h0);
    rst_n = 1'b1;

    // Directed table
    foreach (rows[i]) begin
      drive(rows[i].start, rows[i].stop, rows[i].ack, rows[i].err, rows[i].sens_n);
      repeat (rows[i].hold) tick(rows[i].name);
      check(rows[i].name, 32'(dut_out()),
            32'({rows[i].ena, rows[i].g, rows[i].r, rows[i].src}));
    end

    // Asynchronous reset in the middle of STAGGER
    drive(1, 0, 0, '0, '1);
    tick("pre_rst_start");
    drive(0, 0, 0, '0, '1);
    repeat (10) tick("pre_rst_stag");
    check("pre_rst_ena", 32'(bus.mot_ena), 32'h03);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ena", 32'(bus.mot_ena), 32'h0);
    check("rst_async_leds", 32'({bus.led_green, bus.led_red}), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick("post_rst_idle");
    drive(1, 0, 0, '0, '1);
    tick("restart");
    check("restart_ena", 32'(bus.mot_ena), 32'h01);
    drive(0, 0, 0, '0, '1);
    repeat (GAP) tick("restart_stag");
    check("restart_m1", 32'(bus.mot_ena), 32'h03);

    // Randomised run against the model
    r_err  = '0;
    r_sens = '1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 2) != 0) begin
          r_err  = '0;
          r_sens = '1;
        end else begin
          r_err  = N_MOT'($urandom);
          r_sens = N_SENS'($urandom);
        end
      end
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 5) == 0, r_err, r_sens);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
